// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush control for a 5-stage pipeline plus debug
//               run/halt/single-step FSM. Optional perf counters are built
//               only when PIPE_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int START_RUN    = 1,
  parameter int STEP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_run,
  input  logic        dbg_halt,
  input  logic        dbg_step,
  input  logic [4:0]  id_rf_ra0,
  input  logic [4:0]  id_rf_ra1,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_wa,
  input  logic [1:0]  ex_rf_wd_sel,
  input  logic        ex_br_taken,
  input  logic        mem_busy,
  input  logic        wb_commit,
  output logic        pipe_en,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_stall,
  output logic        ex_mem_flush,
  output logic        mem_wb_stall,
  output logic        mem_wb_flush,
  output logic [1:0]  dbg_state,
  output logic        step_to,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_flushes
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam state_t     c_reset_state = (START_RUN != 0) ? ST_RUN : ST_HALT;
  localparam logic [7:0] c_step_last   = 8'(STEP_TIMEOUT - 1);
  localparam logic [1:0] c_sel_load    = 2'd2;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_step_cnt;
  logic [7:0] w_step_cnt_nxt;
  logic       r_step_to;
  logic       w_step_to_nxt;
  logic       w_load_use;

  // ---------------------------------------------------------------- debug FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_reset_state;
      r_step_cnt <= 8'd0;
      r_step_to  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_step_cnt <= w_step_cnt_nxt;
      r_step_to  <= w_step_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_step_cnt_nxt = r_step_cnt;
    w_step_to_nxt  = r_step_to;
    unique case (r_state)
      ST_HALT: begin
        if (dbg_step) begin
          w_state_nxt    = ST_STEP;
          w_step_cnt_nxt = 8'd0;
          w_step_to_nxt  = 1'b0;
        end else if (dbg_run) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (dbg_halt) begin
          w_state_nxt = ST_HALT;
        end else if (dbg_step) begin
          w_state_nxt    = ST_STEP;
          w_step_cnt_nxt = 8'd0;
          w_step_to_nxt  = 1'b0;
        end
      end
      ST_STEP: begin
        if (r_step_cnt != 8'hFF) begin
          w_step_cnt_nxt = r_step_cnt + 8'd1;
        end
        // A commit at count 0 belongs to an instruction already in flight.
        if (dbg_halt) begin
          w_state_nxt = ST_HALT;
        end else if (dbg_run) begin
          w_state_nxt = ST_RUN;
        end else if (wb_commit && (r_step_cnt >= 8'd1) && !mem_busy) begin
          w_state_nxt = ST_HALT;
        end else if (r_step_cnt == c_step_last) begin
          w_state_nxt   = ST_HALT;
          w_step_to_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_HALT;
      end
    endcase
  end

  assign pipe_en   = !rst && (r_state != ST_HALT);
  assign dbg_state = r_state;
  assign step_to   = r_step_to;

  // ---------------------------------------------------------- hazard control
  assign w_load_use = ex_rf_we && (ex_rf_wd_sel == c_sel_load) && (ex_rf_wa != 5'd0) &&
                      ((ex_rf_wa == id_rf_ra0) || (ex_rf_wa == id_rf_ra1));

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_stall = 1'b0;
    mem_wb_flush = 1'b0;
    if (pipe_en) begin
      if (mem_busy) begin
        // EX is frozen, so a pending branch redirect waits for the memory.
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_br_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  // ---------------------------------------------------- performance counters
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stalls;
  logic [31:0] r_perf_flushes;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cycles  <= 32'd0;
      r_perf_stalls  <= 32'd0;
      r_perf_flushes <= 32'd0;
    end else begin
      if (pipe_en)     r_perf_cycles  <= r_perf_cycles + 32'd1;
      if (pc_stall)    r_perf_stalls  <= r_perf_stalls + 32'd1;
      if (if_id_flush) r_perf_flushes <= r_perf_flushes + 32'd1;
    end
  end

  assign perf_cycles  = r_perf_cycles;
  assign perf_stalls  = r_perf_stalls;
  assign perf_flushes = r_perf_flushes;
`else
  assign perf_cycles  = 32'd0;
  assign perf_stalls  = 32'd0;
  assign perf_flushes = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central control unit for the 5-stage pipeline and its four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates the per-register stall/flush controls and the shared enable consumed by those registers.
- Covers load-use hazards, taken branches/jumps resolved in EX, and data-memory wait states.
- Owns the debug run/halt/single-step state machine and optional performance counters.

Parameters:
- START_RUN, 1, state after reset: 1 = RUN, 0 = HALT.
- STEP_TIMEOUT, 16, maximum cycles spent in STEP before a forced return to HALT (legal range 2..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dbg_run  in  1  one-cycle pulse: resume free run
- dbg_halt  in  1  one-cycle pulse: halt pipeline
- dbg_step  in  1  one-cycle pulse: retire one instruction, then halt
- id_rf_ra0  in  5  ID source register 0
- id_rf_ra1  in  5  ID source register 1
- ex_rf_we  in  1  EX write enable
- ex_rf_wa  in  5  EX destination register
- ex_rf_wd_sel  in  2  EX write-back source; 2 = load
- ex_br_taken  in  1  branch/jump in EX redirects PC
- mem_busy  in  1  data memory not ready
- wb_commit  in  1  commit bit in MEM/WB
- pipe_en  out  1  shared enable for all inter-stage registers and PC
- pc_stall  out  1  PC stall
- if_id_stall  out  1  IF/ID stall
- if_id_flush  out  1  IF/ID flush
- id_ex_stall  out  1  ID/EX stall
- id_ex_flush  out  1  ID/EX flush
- ex_mem_stall  out  1  EX/MEM stall
- ex_mem_flush  out  1  EX/MEM flush
- mem_wb_stall  out  1  MEM/WB stall
- mem_wb_flush  out  1  MEM/WB flush
- dbg_state  out  2  0 = HALT, 1 = RUN, 2 = STEP
- step_to  out  1  sticky flag: last step timed out
- perf_cycles  out  32  cycles with pipe_en = 1
- perf_stalls  out  32  cycles with pc_stall = 1
- perf_flushes  out  32  cycles with if_id_flush = 1

Behaviour:
- Reset (rst = 1 at posedge):
  - State := RUN if START_RUN, else HALT.
  - step_cnt := 0, step_to := 0, all perf counters := 0.
  - While rst is high, every stall/flush output and pipe_en are forced to 0.
- pipe_en:
  - 1 in RUN and STEP; 0 in HALT.
  - Takes effect one cycle after the command pulse, because state is registered.
- Hazard outputs are combinational from the current inputs, evaluated only when pipe_en = 1 (otherwise all 0). Priority, highest first:
  1. mem_busy = 1: pc, if_id, id_ex and ex_mem stall; mem_wb_flush = 1, inserting a bubble into WB. All other flushes = 0. A simultaneous ex_br_taken is deferred, since EX is held.
  2. ex_br_taken = 1: if_id_flush = 1 and id_ex_flush = 1; no stalls. Any load-use hazard is ignored because the younger instruction is squashed.
  3. Load-use:
     - Condition: ex_rf_we and ex_rf_wd_sel = 2 and ex_rf_wa != 0 and (ex_rf_wa == id_rf_ra0 or ex_rf_wa == id_rf_ra1).
     - Response: pc_stall = 1, if_id_stall = 1, id_ex_flush = 1.
  4. Otherwise all stall/flush outputs = 0.
- FSM, command priority halt > step > run when pulses coincide:
  - HALT:
    - dbg_step → STEP, step_cnt := 0, step_to := 0.
    - dbg_run → RUN.
    - dbg_halt → no effect.
  - RUN:
    - dbg_halt → HALT.
    - dbg_step → STEP, step_cnt := 0, step_to := 0.
    - dbg_run → no effect.
  - STEP:
    - step_cnt increments each cycle, saturating.
    - → HALT when wb_commit = 1, step_cnt >= 1 and mem_busy = 0.
    - → HALT with step_to := 1 when step_cnt == STEP_TIMEOUT-1.
    - dbg_halt → HALT (abort, step_to unchanged).
    - dbg_run → RUN.
- step_cnt is 8 bits and does not wrap.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - The three 32-bit counters increment on their stated conditions.
  - Counters wrap modulo 2^32 (0xFFFFFFFF → 0).
  - Counters are cleared only by rst.
- Undefined: perf_cycles, perf_stalls and perf_flushes are tied to 0 and no counter flops exist.

Test Plan:
- START_RUN = 1, deassert rst, with ex_rf_we=1, ex_rf_wd_sel=2, ex_rf_wa=5, id_rf_ra1=5 → dbg_state=1, pipe_en=1, pc_stall=1, if_id_stall=1, id_ex_flush=1; with ex_rf_wa=0 instead → all outputs 0.
- Load-use condition plus ex_br_taken=1 in the same cycle → if_id_flush=1, id_ex_flush=1, pc_stall=0; add mem_busy=1 → pc/if_id/id_ex/ex_mem stalls=1, mem_wb_flush=1, if_id_flush=0.
- In RUN, pulse dbg_halt at cycle 10 → pipe_en=0 from cycle 11, all hazard outputs 0 while halted even with mem_busy=1; dbg_run at cycle 20 → pipe_en=1 from cycle 21.
- In HALT, pulse dbg_step; wb_commit=1 on the 3rd STEP cycle → exactly 3 cycles of pipe_en=1, then dbg_state=0, step_to=0.
- Pulse dbg_step with wb_commit held 0 and STEP_TIMEOUT=16 → 16 STEP cycles, then HALT with step_to=1; the next dbg_step clears step_to.
- With PIPE_PERF_CNT_EN defined, counters preset near wrap via long run (or forced to 0xFFFFFFFE) → after 2 RUN cycles perf_cycles=0x00000000; rst mid-STEP → dbg_state=START_RUN value, counters 0, step_to 0.
